store_monitor: RTL
==================

Name: store_monitor

Overview:
- Synthesizable store-bus monitor placed directly downstream of the pipeline core's memory stage.
- Snoops MemWriteM / ALUResultM / WriteDataM and buffers every store (address, data) in a trace FIFO. The FIFO drains over a valid/ready port to a trace sink, such as a UART or debug bridge.
- Detects a "tohost"-style completion store and reports pass/fail. An optional watchdog flags a hang.
- Replaces bench-only end-of-test checking with hardware that also runs on FPGA.

Parameters:
- DEPTH, 8: trace FIFO entries; must be a power of two, ≥2.
- DONE_ADDR, 32'h00000064: store address that signals test completion.
- PASS_VALUE, 32'h00000019: data value that means pass when stored to DONE_ADDR.
- WD_CYCLES, 1000: watchdog limit in clk cycles after reset release (used only with the macro).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemWriteM  in  1  store strobe from the memory stage
- ALUResultM  in  32  store byte address
- WriteDataM  in  32  store data
- trace_valid  out  1  FIFO head valid
- trace_addr  out  32  head address
- trace_data  out  32  head data
- trace_ready  in  1  sink accepts head
- overflow  out  1  sticky: a store was dropped
- store_count  out  16  stores observed in RUN, saturating at 16'hFFFF
- done  out  1  completion store seen
- pass  out  1  completion data == PASS_VALUE (valid only when done=1)
- timeout  out  1  watchdog expired

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO empty; all outputs 0; trace_addr and trace_data read 0.
  - State = RUN; watchdog counter = 0.
- FSM states: RUN, DONE, TIMEOUT.
  - RUN → DONE: MemWriteM=1 and ALUResultM==DONE_ADDR. In the same edge, pass <= (WriteDataM==PASS_VALUE) and done <= 1.
  - RUN → TIMEOUT: watchdog counter reaches WD_CYCLES-1 and no done store occurs that cycle. A done store in the same cycle wins, giving DONE.
  - DONE and TIMEOUT are terminal until reset. done, pass and timeout hold.
- Capture:
  - In RUN, every cycle with MemWriteM=1 pushes {ALUResultM, WriteDataM} and increments store_count. This includes the completion store itself.
  - In DONE or TIMEOUT, stores are ignored: no push, no count.
- FIFO behaviour:
  - First-word fall-through: trace_valid = !empty, and the head appears the cycle after the push edge (1-cycle latency).
  - Pop occurs on a clk edge where trace_valid && trace_ready.
  - trace_valid, trace_addr and trace_data change only after a pop or a push-into-empty.
  - Empty: trace_ready is ignored.
  - Full with push and no pop: entry dropped, overflow <= 1 (sticky until reset), store_count still increments.
  - Full with push and pop in the same cycle: both occur, no drop.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - The FIFO keeps draining in DONE and TIMEOUT.
- store_count saturates and never wraps.
- Reset mid-operation clears the FIFO contents' visibility (pointers), all flags and the FSM immediately.

Optional Feature:
- Macro: STORE_MON_WATCHDOG_EN.
- Defined: a 32-bit cycle counter runs in RUN, the TIMEOUT state exists, and timeout behaves as above.
- Undefined: no counter and no TIMEOUT state; timeout is tied to 0; WD_CYCLES is unused.

Decomposition:
- Package store_mon_pkg holds:
  - the state enum (RUN, DONE, TIMEOUT);
  - the trace entry struct {addr[31:0], data[31:0]}, 64 bits;
  - the constant for the store_count saturation value.
- One sub-module, store_mon_fifo: a parameterised synchronous FWFT FIFO (push, pop, full, empty, dout).
- FSM, counters and flags live in store_monitor.

Test Plan:
- Three stores with trace_ready=1: (0x0,5), (0x4,3), (0x8,9) → trace outputs each pair once in order, each 1 cycle after its push; store_count=3; overflow=0.
- trace_ready=0 with DEPTH=8 and 10 consecutive stores → 8 entries retained, overflow=1 after the 9th store, store_count=10. Releasing ready then drains exactly the first 8 in order.
- Full FIFO, simultaneous push and pop → no drop, overflow stays 0, occupancy stays 8.
- Store (0x64, 25) → next cycle done=1, pass=1. A later store (0x60, 7) is not captured and store_count is unchanged.
- Store (0x64, 24) → done=1, pass=0.
- With STORE_MON_WATCHDOG_EN and WD_CYCLES=20, no done store → timeout=1 exactly 20 cycles after reset release; done stays 0. Without the macro, timeout stays 0 for 1000 cycles.
- Reset asserted mid-drain with 4 entries queued → trace_valid=0, store_count=0 and all flags 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/store_mon_pkg.sv
// Shared types and constants for the store-bus monitor.
// The TIMEOUT state exists only when STORE_MON_WATCHDOG_EN is defined.
package store_mon_pkg;

`ifdef STORE_MON_WATCHDOG_EN
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2
  } mon_state_t;
`else
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1
  } mon_state_t;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  localparam logic [15:0] STORE_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/store_mon_fifo.sv
// First-word fall-through trace FIFO; the head reads as zero while empty.
// Pointers carry one extra wrap bit to tell full from empty.
module store_mon_fifo
  import store_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  trace_entry_t din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output trace_entry_t dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;
  trace_entry_t mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/store_monitor.sv
// Store-bus monitor: traces every store, detects the completion store, reports pass/fail.
// Define STORE_MON_WATCHDOG_EN to add the hang watchdog and the TIMEOUT state.
module store_monitor
  import store_mon_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] DONE_ADDR  = 32'h00000064,
  parameter logic [31:0] PASS_VALUE = 32'h00000019,
  parameter int unsigned WD_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  input  logic        trace_ready,
  output logic        overflow,
  output logic [15:0] store_count,
  output logic        done,
  output logic        pass,
  output logic        timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WD_CYCLES < 1) begin : g_bad_cfg
    $error("store_monitor: DEPTH must be a power of two >= 2 and WD_CYCLES >= 1");
  end

  mon_state_t   state;
  mon_state_t   state_nxt;
  logic         running;
  logic         push;
  logic         pop;
  logic         done_store;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pass_q;
  logic         ovf_q;
  logic [15:0]  count_q;
  trace_entry_t entry_in;
  trace_entry_t head;

  assign running    = (state == RUN);
  assign push       = running && MemWriteM;
  assign done_store = push && (ALUResultM == DONE_ADDR);
  assign pop        = trace_valid && trace_ready;

`ifdef STORE_MON_WATCHDOG_EN
  logic [31:0] wd_cnt;
  logic        wd_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wd_cnt <= '0;
    else if (running) wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_expire = running && (wd_cnt == 32'(WD_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // A completion store in the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (done_store) state_nxt = DONE;
`ifdef STORE_MON_WATCHDOG_EN
        else if (wd_expire) state_nxt = TIMEOUT;
`endif
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    done    = 1'b0;
    timeout = 1'b0;
    case (state)
      DONE:    done = 1'b1;
`ifdef STORE_MON_WATCHDOG_EN
      TIMEOUT: timeout = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      if (done_store) pass_q <= (WriteDataM == PASS_VALUE);
      if (push && fifo_full && !trace_ready) ovf_q <= 1'b1;
      if (push && (count_q != STORE_COUNT_MAX)) count_q <= count_q + 16'd1;
    end
  end

  assign entry_in = '{addr: ALUResultM, data: WriteDataM};

  store_mon_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (entry_in),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (head)
  );

  assign trace_valid = !fifo_empty;
  assign trace_addr  = head.addr;
  assign trace_data  = head.data;
  assign overflow    = ovf_q;
  assign store_count = count_q;
  assign pass        = pass_q;

endmodule
